// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Purpose:
//   Shares the single register-file write port between two writeback
//   requesters: requester 0 (ALU result) and requester 1 (load data).
//   At most one requester is granted per cycle. The winner's address and
//   data are registered onto the write port one cycle after the transfer,
//   together with the select for the downstream 2:1 writeback mux.
//   A saturating counter records how many cycles both requesters were
//   valid at once, for performance debug.
//
// Arbitration:
//   The FSM state is the last granted requester (L0 / L1). A lone request
//   is always granted. When both are valid the requester that did not win
//   last time is granted (round-robin). After reset the state is L1, so the
//   ALU wins the first contention.
//
// Compile-time option:
//   WBARB_FIXED_PRIO_EN - when defined, the load requester always wins a
//   contention. last_grant still tracks the winner but does not influence
//   the decision. The contention counter behaves identically.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   req0_valid     in   ALU writeback request
//   req0_addr      in   ALU destination register       [ADDR_W]
//   req0_data      in   ALU result                     [DATA_W]
//   req0_ready     out  ALU request accepted this cycle (combinational)
//   req1_valid     in   load writeback request
//   req1_addr      in   load destination register      [ADDR_W]
//   req1_data      in   load data                      [DATA_W]
//   req1_ready     out  load request accepted this cycle (combinational)
//   wr_en          out  register-file write enable (registered)
//   wr_addr        out  register-file write address    [ADDR_W] (registered)
//   wr_data        out  register-file write data       [DATA_W] (registered)
//   mux_sel        out  writeback mux select, 0 = ALU, 1 = load (registered)
//   contention_cnt out  saturating count of cycles with both valid [CNT_W]
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              mux_sel,
    output logic [CNT_W-1:0]  contention_cnt
);

    // Last granted requester.
    typedef enum logic {
        L0 = 1'b0,
        L1 = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic              grant0;
    logic              grant1;
    logic              both_valid;
    logic              xfer;
    logic              sel_next;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] data_next;
    logic              wr_en_next;
    logic              cnt_sat;

    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [DATA_W-1:0] wr_data_reg;
    logic              mux_sel_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;

    assign both_valid = req0_valid & req1_valid;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // L1 so that the ALU wins the very first contention.
            state_reg <= L1;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: grant decision and next state
    // -------------------------------------------------------------------------
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        state_next = state_reg;
        unique case ({req1_valid, req0_valid})
            2'b01: begin
                grant0     = 1'b1;
                state_next = L0;
            end
            2'b10: begin
                grant1     = 1'b1;
                state_next = L1;
            end
            2'b11: begin
`ifdef WBARB_FIXED_PRIO_EN
                // Load always wins; state still follows the winner.
                grant1     = 1'b1;
                state_next = L1;
`else
                // Grant whoever did not win last time.
                if (state_reg == L1) begin
                    grant0     = 1'b1;
                    state_next = L0;
                end else begin
                    grant1     = 1'b1;
                    state_next = L1;
                end
`endif
            end
            default: begin
                // Neither valid: no grant, state holds.
            end
        endcase
    end

    // Readies depend only on the valids and the FSM state, never on wr_*.
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // -------------------------------------------------------------------------
    // Winner selection for the write port
    // -------------------------------------------------------------------------
    always_comb begin
        xfer       = grant0 | grant1;
        sel_next   = grant1;
        addr_next  = grant1 ? req1_addr : req0_addr;
        data_next  = grant1 ? req1_data : req0_data;
        // x0 is hard-wired zero: the transfer is accepted but never written.
        wr_en_next = xfer && (addr_next != '0);
    end

    // -------------------------------------------------------------------------
    // Contention counter (saturating)
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_sat  = (cnt_reg == {CNT_W{1'b1}});
        cnt_next = cnt_reg;
        if (both_valid && !cnt_sat) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Write-port registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
            mux_sel_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            wr_en_reg <= wr_en_next;
            // Address, data and select follow the latest accepted request
            // and hold otherwise; wr_en alone qualifies the write.
            if (xfer) begin
                wr_addr_reg <= addr_next;
                wr_data_reg <= data_next;
                mux_sel_reg <= sel_next;
            end
            cnt_reg <= cnt_next;
        end
    end

    assign wr_en          = wr_en_reg;
    assign wr_addr        = wr_addr_reg;
    assign wr_data        = wr_data_reg;
    assign mux_sel        = mux_sel_reg;
    assign contention_cnt = cnt_reg;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Directed scenarios followed by a randomized phase. A behavioural model of
// the arbitration rules runs in a single compare process on every falling
// edge and checks readies and registered outputs against the DUT. Directed
// scenarios add hand-computed literal expectations. The DUT is built with
// CNT_W=4 so counter saturation is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef WBARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic              req0_valid = 1'b0;
    logic [ADDR_W-1:0] req0_addr  = '0;
    logic [DATA_W-1:0] req0_data  = '0;
    logic              req0_ready;
    logic              req1_valid = 1'b0;
    logic [ADDR_W-1:0] req1_addr  = '0;
    logic [DATA_W-1:0] req1_data  = '0;
    logic              req1_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              mux_sel;
    logic [CNT_W-1:0]  contention_cnt;

    int errors = 0;
    int checks = 0;

    // Acceptance seen just before the last rising edge.
    bit acc0 = 1'b0;
    bit acc1 = 1'b0;

    // Behavioural model state.
    bit              model_on = 1'b0;
    int              m_last;
    bit              m_wr_en;
    int              m_addr;
    longint unsigned m_data;
    int              m_sel;
    bit              m_known;
    int              m_cnt;

    wb_port_arbiter #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req0_valid    (req0_valid),
        .req0_addr     (req0_addr),
        .req0_data     (req0_data),
        .req0_ready    (req0_ready),
        .req1_valid    (req1_valid),
        .req1_addr     (req1_addr),
        .req1_data     (req1_data),
        .req1_ready    (req1_ready),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .mux_sel       (mux_sel),
        .contention_cnt(contention_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] rand_nz_addr();
        return ADDR_W'($urandom_range(1, (1 << ADDR_W) - 1));
    endfunction

    // -------------------------------------------------------------------------
    // Compare process: model of the arbitration rules, checked every cycle.
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        int w;
        int a;
        longint unsigned d;
        if (!rst_n) begin
            model_on = 1'b1;
            m_last   = 1;
            m_wr_en  = 1'b0;
            m_addr   = 0;
            m_data   = 0;
            m_sel    = 0;
            m_known  = 1'b1;
            m_cnt    = 0;
        end
        if (model_on) begin
            if (req0_valid && req1_valid) w = FIXED ? 1 : 1 - m_last;
            else if (req0_valid)          w = 0;
            else if (req1_valid)          w = 1;
            else                          w = -1;

            chk("req0_ready", req0_ready, 64'(w == 0));
            chk("req1_ready", req1_ready, 64'(w == 1));
            chk("wr_en", wr_en, 64'(m_wr_en));
            chk("contention_cnt", contention_cnt, 64'(m_cnt));
            if (m_known) begin
                chk("wr_addr", wr_addr, 64'(m_addr));
                chk("wr_data", wr_data, m_data);
                chk("mux_sel", mux_sel, 64'(m_sel));
            end

            if (rst_n) begin
                m_wr_en = 1'b0;
                if (w >= 0) begin
                    a = (w == 1) ? int'(req1_addr) : int'(req0_addr);
                    d = (w == 1) ? longint'(req1_data) : longint'(req0_data);
                    $display("xfer t=%0t req%0d addr=%0d data=0x%08h", $time, w, a, d);
                    if (a != 0) begin
                        m_wr_en = 1'b1;
                        m_addr  = a;
                        m_data  = d;
                        m_sel   = w;
                        m_known = 1'b1;
                    end else begin
                        m_known = 1'b0;
                    end
                    m_last = w;
                end
                if (req0_valid && req1_valid && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic do_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        acc0       = 1'b0;
        acc1       = 1'b0;
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_cnt", contention_cnt, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_mux_sel", mux_sel, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Both requesters stay valid; an accepted requester presents new data.
    task automatic contend(input int n, input bit check_alt, input string tag);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (!req0_valid || acc0) begin
                req0_valid = 1'b1;
                req0_addr  = rand_nz_addr();
                req0_data  = $urandom;
            end
            if (!req1_valid || acc1) begin
                req1_valid = 1'b1;
                req1_addr  = rand_nz_addr();
                req1_data  = $urandom;
            end
            #2;
            if (check_alt) begin
                chk($sformatf("%s_onehot%0d", tag, k), req0_ready ^ req1_ready, 1);
                chk($sformatf("%s_grant%0d", tag, k), req1_ready, FIXED ? 1 : (k % 2));
            end
            #1;
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
        end
    endtask

    // Let the pending requester finish after a contend run.
    task automatic drain();
        @(posedge clk);
        #1;
        if (acc0) req0_valid = 1'b0;
        if (acc1) req1_valid = 1'b0;
        #3;
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        acc0 = 1'b0;
        acc1 = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        logic [ADDR_W-1:0] ta [2];
        logic [DATA_W-1:0] td [2];
        int f;
        ta[0] = 5'd4;  ta[1] = 5'd5;
        td[0] = 32'h11; td[1] = 32'h22;

        #2;
        do_reset();

        // Single ALU request.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hDEADBEEF;
        #2;
        chk("t1_req0_ready", req0_ready, 1);
        chk("t1_req1_ready", req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        chk("t1_wr_en", wr_en, 1);
        chk("t1_wr_addr", wr_addr, 3);
        chk("t1_wr_data", wr_data, 32'hDEADBEEF);
        chk("t1_mux_sel", mux_sel, 0);
        @(posedge clk); #1;
        chk("t1_idle_wr_en", wr_en, 0);
        chk("t1_hold_addr", wr_addr, 3);

        // Contention right after reset.
        do_reset();
        f = FIXED ? 1 : 0;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_addr = ta[0]; req0_data = td[0];
        req1_valid = 1'b1; req1_addr = ta[1]; req1_data = td[1];
        #2;
        chk("t2_req0_ready", req0_ready, FIXED ? 0 : 1);
        chk("t2_req1_ready", req1_ready, FIXED ? 1 : 0);
        @(posedge clk); #1;
        if (f == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
        chk("t2_first_wr_en", wr_en, 1);
        chk("t2_first_addr", wr_addr, 64'(ta[f]));
        chk("t2_first_data", wr_data, 64'(td[f]));
        chk("t2_first_sel", mux_sel, 64'(f));
        #2;
        chk("t2_second_ready", (f == 1) ? req0_ready : req1_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("t2_second_addr", wr_addr, 64'(ta[1-f]));
        chk("t2_second_data", wr_data, 64'(td[1-f]));
        chk("t2_second_sel", mux_sel, 64'(1 - f));
        chk("t2_cnt", contention_cnt, 1);
        chk("t2_model_cnt", 64'(m_cnt), 1);

        // Sustained contention: alternating grants (or all load when fixed).
        contend(6, 1'b1, "t3");
        drain();
        chk("t3_cnt", contention_cnt, 7);

        // Write to x0 is accepted but not written.
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFFFFFF;
        #2;
        chk("t4_req1_ready", req1_ready, 1);
        chk("t4_req0_ready", req0_ready, 0);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        chk("t4_wr_en", wr_en, 0);
        chk("t4_model_last", 64'(m_last), 1);
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'hA5A5A5A5;
        req1_valid = 1'b1; req1_addr = 5'd8; req1_data = 32'h5A5A5A5A;
        #2;
        chk("t4_next_req0_ready", req0_ready, FIXED ? 0 : 1);
        @(posedge clk); #1;
        if (FIXED) req1_valid = 1'b0; else req0_valid = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Counter saturation.
        do_reset();
        contend(20, 1'b0, "t5");
        drain();
        chk("t5_cnt_sat", contention_cnt, CNT_MAX);
        chk("t5_model_sat", 64'(m_cnt), CNT_MAX);

        // Asynchronous reset in the middle of contention.
        contend(3, 1'b0, "t6pre");
        @(posedge clk); #3;
        do_reset();
        contend(4, 1'b1, "t6post");
        drain();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                continue;
            end
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom_range(0, 9) < 6);
                req0_addr  = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom);
                req0_data  = $urandom;
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom_range(0, 9) < 6);
                req1_addr  = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom);
                req1_data  = $urandom;
            end
            #3;
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Arbitrates the single register-file write port between two writeback requesters: requester 0 (ALU result) and requester 1 (load data). Grants at most one requester per cycle and registers the winner's address and data onto the write port. Drives the registered select for the downstream 32-bit 2:1 writeback mux. Keeps a saturating count of contention cycles for performance debug.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, width of register address
CNT_W, 16, width of contention counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  ALU writeback request
req0_addr  input  ADDR_W  ALU destination register
req0_data  input  DATA_W  ALU result
req0_ready  output  1  ALU request accepted this cycle
req1_valid  input  1  load writeback request
req1_addr  input  ADDR_W  load destination register
req1_data  input  DATA_W  load data
req1_ready  output  1  load request accepted this cycle
wr_en  output  1  register-file write enable (registered)
wr_addr  output  ADDR_W  register-file write address (registered)
wr_data  output  DATA_W  register-file write data (registered)
mux_sel  output  1  writeback mux select: 0 = ALU, 1 = load (registered)
contention_cnt  output  CNT_W  saturating count of cycles with both valid

Behaviour:
- Reset (async assert, sync-safe deassert): wr_en=0, wr_addr=0, wr_data=0, mux_sel=0, contention_cnt=0, last_grant=1 (so req0 wins first contention).
- req*_ready is combinational from the valids and last_grant; never depends on wr_* outputs. Transfer = valid && ready.
- Requester rule: once valid is high, addr/data stay stable and valid stays high until ready.
- FSM state is last_grant (L0, L1):
  - Only req0 valid: grant 0, next state L0.
  - Only req1 valid: grant 1, next state L1.
  - Both valid: grant the requester not in last_grant (L1 -> grant 0, L0 -> grant 1); next state = granted requester.
  - Neither valid: no grant, state unchanged.
- Exactly one ready high at most per cycle; no ready without its valid.
- Latency: a transfer in cycle N gives wr_en=1, wr_addr/wr_data of the winner, and mux_sel = winner index in cycle N+1. No transfer gives wr_en=0 in N+1. wr_addr, wr_data and mux_sel hold their last values.
- Address 0: the transfer completes (ready asserted, state advances) but wr_en=0 in N+1. x0 is never written.
- Both requesters targeting the same address: normal arbitration; the writes appear on consecutive granted cycles in grant order.
- contention_cnt increments by 1 on every cycle with both valid; saturates at 2^CNT_W-1.
- Reset mid-stream: pending requests are dropped; requesters re-present after reset.

Optional Feature:
WBARB_FIXED_PRIO_EN
- Defined: fixed priority, req1 (load) always wins contention; last_grant still updates but is ignored for the decision. contention_cnt is unchanged.
- Undefined: round-robin as above.

Test Plan:
- Reset then single request: req0 addr=3, data=0xDEADBEEF for 1 cycle -> req0_ready=1 same cycle; next cycle wr_en=1, wr_addr=3, wr_data=0xDEADBEEF, mux_sel=0.
- Contention after reset: both valid (req0 addr=4 data=0x11, req1 addr=5 data=0x22) held until accepted -> cycle N grants req0, N+1 grants req1; wr_* shows 4/0x11/sel 0, then 5/0x22/sel 1; contention_cnt=1.
- Sustained contention for 6 cycles, new data on each accept -> grants alternate 0,1,0,1,0,1; never two readies high in one cycle.
- Write to x0: req1 addr=0 data=0xFFFFFFFF -> req1_ready=1; next cycle wr_en=0; last_grant becomes L1.
- Counter saturation with CNT_W=4 and both valid for 20 cycles -> contention_cnt reaches 15 and holds.
- Async reset asserted mid-contention -> wr_en=0, contention_cnt=0 immediately. After release, the first contention grants req0. With WBARB_FIXED_PRIO_EN, the same stimulus grants req1 on every contended cycle.
